count_checker: RTL and testbench
================================

Name: count_checker

Overview:
- Downstream consumer of the free-running 8-bit counter stage.
- Samples the counter value and its registered is-one flag every clock and locks onto the increment sequence.
- Counts wrap-arounds, and counts and flags any sequence break.
- Used as an on-chip self-check / bench monitor placed directly after the counter.

Parameters:
WIDTH, 8, width of sampled counter value count_in
ERRW, 4, width of saturating error counter err_count
WRAPW, 8, width of wrap counter wrap_count (modulo 2^WRAPW)

Ports:
clk  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset; clears all state immediately when low
en  input  1  sample enable; 0 forces relock
clr  input  1  synchronous clear of err_count, err_sticky, wrap_count
count_in  input  WIDTH  counter value from upstream stage
one_in  input  1  upstream registered flag, high when previous count_in was 1
locked  output  1  high while in TRACK
err_sticky  output  1  set on first counted mismatch; held until clr or reset
err_pulse  output  1  one-cycle pulse per counted mismatch
err_count  output  ERRW  mismatches counted, saturates at 2^ERRW-1
wrap_count  output  WRAPW  number of max->0 transitions seen in TRACK, wraps modulo 2^WRAPW
state  output  2  FSM state: 0 IDLE, 1 SYNC, 2 TRACK (3 unused)

Behaviour:
- Reset (reset=0, asynchronous, active-low):
  - state=IDLE, prev=0.
  - All outputs 0.
  - Release is sampled on the next posedge.
- All outputs are registered. The response to the sample taken at edge t is visible after edge t; no combinational path from inputs to outputs.
- en=0 in any state: next state IDLE, locked=0. Counters and sticky are held.
- IDLE: on en=1, prev<=count_in and go to SYNC.
- SYNC (en=1):
  - count_in==prev+1 mod 2^WIDTH: go to TRACK, locked=1.
  - Otherwise: prev<=count_in, stay in SYNC, nothing counted.
- TRACK (en=1): expected value is prev+1 mod 2^WIDTH.
  - Match: prev<=count_in, stay in TRACK.
    - If additionally prev==2^WIDTH-1 and count_in==0, wrap_count increments.
  - Mismatch:
    - err_pulse=1 for one cycle, err_sticky<=1.
    - err_count increments unless already all-ones (saturates, no wrap).
    - prev<=count_in, state SYNC, locked=0.
- Only mismatches detected in TRACK are counted.
- clr=1:
  - Forces err_count, wrap_count and err_sticky to 0 on that edge.
  - clr wins over a simultaneous increment or set.
  - FSM transitions and err_pulse still occur as normal.
- Reset asserted mid-operation aborts everything immediately; no partial update is retained.
- Width rule: increment and compare are done at WIDTH bits, so 2^WIDTH-1 -> 0 is a legal increment.

Optional Feature:
Macro ONE_FLAG_CHECK_EN.
- Defined:
  - In TRACK, also require one_in == (prev==1), using prev before update. This models the one-cycle lag of the upstream non-blocking flag.
  - A violation is a mismatch with identical handling.
  - A value mismatch and a flag violation in the same cycle count once.
  - In IDLE/SYNC one_in is ignored.
- Not defined: one_in is unused and has no effect on any output.

Test Plan:
- Reset low with inputs toggling -> all outputs 0, state=0. Release, en=1, count_in 5,6,7 -> state 1 after first edge, locked=1 after second edge, err_count=0.
- Locked, count_in 254,255,0,1 -> wrap_count=1, err_count=0, locked stays 1.
- Locked at 10, then count_in 12 -> err_pulse=1 for exactly one cycle, err_sticky=1, err_count=1, state=SYNC. Then 13 -> locked=1 again, err_count still 1.
- Force 20 consecutive mismatches with ERRW=4, each followed by a relock -> err_count=15 (saturated). Then clr=1 concurrent with a mismatch -> err_count=0, err_sticky=0, err_pulse=1, state=SYNC.
- Locked, en=0 for 1 cycle -> state=IDLE, locked=0, counters held. en=1 with count_in 40,41 -> relocked after two edges, err_count unchanged.
- ONE_FLAG_CHECK_EN defined, locked, count_in 1,2 with one_in=0 on the sample where count_in=2 -> err_count=1. Same sequence with one_in=1 -> no error. Without the macro, one_in=0 -> no error.

Source files
------------

// File: rtl/count_checker.sv
// count_checker
//
// Checker that sits directly after the free-running WIDTH-bit counter stage.
// It samples the counter value every clock, locks onto the increment
// sequence, counts max->0 wrap-arounds while locked and flags any sequence
// break seen while locked.
//
// Optional feature (compile-time macro ONE_FLAG_CHECK_EN):
//   When defined, the upstream registered is-one flag (one_in) is also
//   checked while tracking. It must equal (prev == 1), because the upstream
//   flag lags its count by one cycle. A flag violation is handled exactly
//   like a value mismatch, and both in one cycle count once. When the macro
//   is not defined, one_in has no effect on any output.
//
// Ports:
//   clk         single clock, all state updates on posedge
//   reset       asynchronous active-low reset, clears all state when low
//   en          sample enable; low forces a relock (back to IDLE)
//   clr         synchronous clear of err_count, err_sticky, wrap_count
//   count_in    counter value from the upstream stage
//   one_in      upstream registered flag, high when previous count_in was 1
//   locked      high while in TRACK
//   err_sticky  set on first counted mismatch, held until clr or reset
//   err_pulse   one-cycle pulse per counted mismatch
//   err_count   saturating count of mismatches seen in TRACK
//   wrap_count  max->0 transitions seen in TRACK, modulo 2^WRAPW
//   state       FSM state: 0 IDLE, 1 SYNC, 2 TRACK
module count_checker #(
  parameter int WIDTH = 8,
  parameter int ERRW  = 4,
  parameter int WRAPW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] count_in,
  input  logic             one_in,
  output logic             locked,
  output logic             err_sticky,
  output logic             err_pulse,
  output logic [ERRW-1:0]  err_count,
  output logic [WRAPW-1:0] wrap_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t           cur;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] expected;
  logic             seq_ok;
  logic             flag_ok;
  logic             mismatch;
  logic             is_wrap;

  // The increment is done at WIDTH bits so that all-ones -> 0 is legal.
  assign expected = prev + WIDTH'(1);
  assign seq_ok   = (count_in == expected);

`ifdef ONE_FLAG_CHECK_EN
  // The upstream flag describes the value one cycle older than count_in,
  // i.e. the value we hold in prev before this update.
  assign flag_ok = (one_in == (prev == WIDTH'(1)));
`else
  logic unused_one_in;
  assign unused_one_in = one_in;
  assign flag_ok       = 1'b1;
`endif

  // A value break and a flag break in the same cycle are one mismatch.
  assign mismatch = !(seq_ok && flag_ok);
  assign is_wrap  = (prev == {WIDTH{1'b1}}) && (count_in == '0);

  assign state = cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur        <= IDLE;
      prev       <= '0;
      locked     <= 1'b0;
      err_sticky <= 1'b0;
      err_pulse  <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      err_pulse <= 1'b0;

      // Dropping en always forces a relock; counters and sticky are held.
      if (!en) begin
        cur    <= IDLE;
        locked <= 1'b0;
      end else begin
        unique case (cur)
          IDLE: begin
            prev   <= count_in;
            cur    <= SYNC;
            locked <= 1'b0;
          end
          SYNC: begin
            // Nothing is counted while searching for the sequence.
            prev <= count_in;
            if (seq_ok) begin
              cur    <= TRACK;
              locked <= 1'b1;
            end
          end
          TRACK: begin
            prev <= count_in;
            if (mismatch) begin
              err_pulse  <= 1'b1;
              err_sticky <= 1'b1;
              if (err_count != {ERRW{1'b1}}) begin
                err_count <= err_count + ERRW'(1);
              end
              cur    <= SYNC;
              locked <= 1'b0;
            end else if (is_wrap) begin
              wrap_count <= wrap_count + WRAPW'(1);
            end
          end
          default: begin
            cur    <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end

      // Clear wins over any increment or set made on the same edge;
      // the FSM and err_pulse behave as normal.
      if (clr) begin
        err_count  <= '0;
        wrap_count <= '0;
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker
//
// Scoreboard bench for count_checker. Each stimulus step predicts the
// outputs from a behavioural model of the checker rules and pushes them into
// a queue; a separate monitor pops and compares one entry per clock edge.
// Directed sequences cover lock, wrap, error, saturation, clear, enable
// drop, the optional one-flag check and async reset; a randomized phase
// follows.
module tb_count_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] count_in = 8'd0;
  logic       one_in = 1'b0;
  logic       locked;
  logic       err_sticky;
  logic       err_pulse;
  logic [3:0] err_count;
  logic [7:0] wrap_count;
  logic [1:0] state;

  count_checker #(.WIDTH(8), .ERRW(4), .WRAPW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .clr        (clr),
    .count_in   (count_in),
    .one_in     (one_in),
    .locked     (locked),
    .err_sticky (err_sticky),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .wrap_count (wrap_count),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       lck;
    logic       sticky;
    logic       pulse;
    logic [3:0] errc;
    logic [7:0] wrapc;
    logic [1:0] st;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Behavioural model: "have_ref" means a reference sample exists,
  // "tracking" means the last step continued the increment sequence.
  bit m_have_ref;
  bit m_tracking;
  int m_ref;
  int m_err;
  int m_wrap;
  bit m_sticky;
  bit m_pulse;
  int last_cnt = 0;

  function automatic void model_reset();
    m_have_ref = 0;
    m_tracking = 0;
    m_ref      = 0;
    m_err      = 0;
    m_wrap     = 0;
    m_sticky   = 0;
    m_pulse    = 0;
  endfunction

  function automatic void model_step(bit e, bit c, int v, bit one);
    bit ok;
    m_pulse = 0;
    if (!e) begin
      m_have_ref = 0;
      m_tracking = 0;
    end else if (!m_have_ref) begin
      m_have_ref = 1;
      m_ref      = v;
    end else if (!m_tracking) begin
      if (v == (m_ref + 1) % 256) m_tracking = 1;
      m_ref = v;
    end else begin
      ok = (v == (m_ref + 1) % 256);
`ifdef ONE_FLAG_CHECK_EN
      if (one != (m_ref == 1)) ok = 0;
`endif
      if (ok) begin
        if (m_ref == 255 && v == 0) m_wrap = (m_wrap + 1) % 256;
      end else begin
        m_pulse    = 1;
        m_sticky   = 1;
        m_err      = (m_err < 15) ? m_err + 1 : 15;
        m_tracking = 0;
      end
      m_ref = v;
    end
    if (c) begin
      m_err    = 0;
      m_wrap   = 0;
      m_sticky = 0;
    end
  endfunction

  function automatic exp_t model_snapshot();
    exp_t s;
    s.lck    = m_tracking;
    s.sticky = m_sticky;
    s.pulse  = m_pulse;
    s.errc   = 4'(m_err);
    s.wrapc  = 8'(m_wrap);
    s.st     = !m_have_ref ? 2'd0 : (m_tracking ? 2'd2 : 2'd1);
    return s;
  endfunction

  task automatic checkOutput(input string name, input exp_t e);
    exp_t got;
    got = {locked, err_sticky, err_pulse, err_count, wrap_count, state};
    tests++;
    if (got !== e) begin
      fails++;
      $display("[TB] FAIL %s @%0t: got locked=%0d sticky=%0d pulse=%0d err=%0d wrap=%0d state=%0d, want locked=%0d sticky=%0d pulse=%0d err=%0d wrap=%0d state=%0d",
               name, $time, got.lck, got.sticky, got.pulse, got.errc, got.wrapc, got.st,
               e.lck, e.sticky, e.pulse, e.errc, e.wrapc, e.st);
    end
  endtask

  task automatic checkField(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("[TB] FAIL %s @%0t: got %0d, want %0d", name, $time, got, want);
    end
  endtask

  // Drive one sample at the falling edge and predict the next posedge.
  task automatic applyStimulus(input bit e, input bit c, input int v, input bit one);
    @(negedge clk);
    en       = e;
    clr      = c;
    count_in = 8'(v);
    one_in   = one;
    last_cnt = v % 256;
    if (!reset) model_reset();
    else        model_step(e, c, v % 256, one);
    q.push_back(model_snapshot());
  endtask

  // Same, with one_in produced the way a healthy upstream stage would.
  task automatic drive(input bit e, input bit c, input int v);
    applyStimulus(e, c, v, last_cnt == 1);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one scoreboard entry per posedge, sampled after it settles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checkOutput("cycle", e);
      end
    end
  end

  initial begin
    int v;
    int err_before;
    exp_t zero;
    zero = '0;
    model_reset();

    // Reset held with inputs toggling.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'($urandom), 1'($urandom), int'($urandom_range(0, 255)), 1'($urandom));
    settle();
    checkOutput("reset_state", zero);

    // Lock onto 5,6,7.
    @(negedge clk);
    reset = 1'b1;
    drive(1, 0, 5);
    settle();
    checkField("sync_after_first", int'(state), 1);
    drive(1, 0, 6);
    settle();
    checkField("locked_after_second", int'(locked), 1);
    drive(1, 0, 7);
    settle();
    checkField("no_err_lock", int'(err_count), 0);

    // Wrap-around while tracking.
    drive(0, 0, 0);
    for (int k = 252; k <= 257; k++) drive(1, 0, k % 256);
    settle();
    checkField("wrap_once", int'(wrap_count), 1);
    checkField("wrap_no_err", int'(err_count), 0);
    checkField("wrap_locked", int'(locked), 1);

    // Single mismatch at 10 -> 12, then relock on 13.
    drive(0, 0, 0);
    drive(1, 0, 9);
    drive(1, 0, 10);
    drive(1, 0, 12);
    settle();
    checkField("mm_pulse", int'(err_pulse), 1);
    checkField("mm_err", int'(err_count), 1);
    checkField("mm_state", int'(state), 1);
    drive(1, 0, 13);
    settle();
    checkField("mm_pulse_gone", int'(err_pulse), 0);
    checkField("mm_relock", int'(locked), 1);

    // 20 mismatches with relock: saturation at 15.
    v = 13;
    for (int i = 0; i < 20; i++) begin
      v = (v + 2) % 256;
      drive(1, 0, v);
      v = (v + 1) % 256;
      drive(1, 0, v);
    end
    settle();
    checkField("err_saturated", int'(err_count), 15);

    // Clear concurrent with a mismatch.
    drive(1, 1, (v + 5) % 256);
    settle();
    checkField("clr_err", int'(err_count), 0);
    checkField("clr_sticky", int'(err_sticky), 0);
    checkField("clr_pulse", int'(err_pulse), 1);
    checkField("clr_state", int'(state), 1);

    // Enable drop while locked, then relock on 40,41.
    drive(1, 0, 30);
    drive(1, 0, 31);
    drive(0, 0, 32);
    settle();
    checkField("en0_state", int'(state), 0);
    checkField("en0_locked", int'(locked), 0);
    drive(1, 0, 40);
    drive(1, 0, 41);
    settle();
    checkField("en_relock", int'(locked), 1);
    checkField("en_err_held", int'(err_count), 0);

    // One-flag check: lock at 1, then sample 2 with one_in forced.
    err_before = int'(err_count);
    drive(0, 0, 0);
    drive(1, 0, 0);
    drive(1, 0, 1);
    applyStimulus(1, 0, 2, 1'b0);
    settle();
`ifdef ONE_FLAG_CHECK_EN
    checkField("flag_bad", int'(err_count), err_before + 1);
`else
    checkField("flag_ignored", int'(err_count), err_before);
`endif
    err_before = int'(err_count);
    drive(0, 0, 0);
    drive(1, 0, 0);
    drive(1, 0, 1);
    applyStimulus(1, 0, 2, 1'b1);
    settle();
    checkField("flag_good", int'(err_count), err_before);

    // Asynchronous reset mid-operation.
    drive(1, 0, 3);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset", zero);
    model_reset();
    drive(1, 0, 4);
    @(negedge clk);
    reset = 1'b1;

    // Randomized phase.
    v = 0;
    for (int i = 0; i < 2000; i++) begin
      bit e, c, one;
      e = ($urandom_range(0, 99) >= 3);
      c = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 6) v = int'($urandom_range(0, 255));
      else                           v = (v + 1) % 256;
      one = (last_cnt == 1);
      if ($urandom_range(0, 99) < 5) one = !one;
      applyStimulus(e, c, v, one);
    end

    repeat (3) @(negedge clk);
    checkField("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
